// File: rtl/fault_log_pkg.sv
// Shared types and helpers for the fault event logger: record layout, FSM states
// and a saturating increment used by all statistics counters.
package fault_log_pkg;

   typedef enum logic [0:0] {MONITOR = 1'b0, ALARM = 1'b1} state_t;

   // Record layout, LSB first: used_scale, true_scale, used_sum, true_sum, mode
   function automatic int rec_w(input int nbits, input int scale_w);
      return 2*nbits + 2*scale_w + 1;
   endfunction

   function automatic int off_true_sum(input int nbits, input int scale_w);
      return 2*scale_w + nbits;
   endfunction

   function automatic int off_mode(input int nbits, input int scale_w);
      return 2*scale_w + 2*nbits;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
      return (v >= lim) ? lim : v + 32'd1;
   endfunction

endpackage

// File: rtl/fault_event_logger_if.sv
// Sample input bus from the posit add fault checker plus the event-record
// valid/ready output stream.
interface fault_event_logger_if #(
   parameter int NBITS   = 32,
   parameter int SCALE_W = 7
);
   import fault_log_pkg::*;
   localparam int REC_W = rec_w(NBITS, SCALE_W);

   logic               in_valid;
   logic               in_fault;
   logic               in_mode;
   logic [NBITS-1:0]   in_true_sum;
   logic [NBITS-1:0]   in_used_sum;
   logic [SCALE_W-1:0] in_true_scale;
   logic [SCALE_W-1:0] in_used_scale;
   logic               ev_valid;
   logic               ev_ready;
   logic [REC_W-1:0]   ev_data;

   modport master (
      output in_valid, in_fault, in_mode, in_true_sum, in_used_sum,
             in_true_scale, in_used_scale, ev_ready,
      input  ev_valid, ev_data
   );

   modport slave (
      input  in_valid, in_fault, in_mode, in_true_sum, in_used_sum,
             in_true_scale, in_used_scale, ev_ready,
      output ev_valid, ev_data
   );
endinterface

// File: rtl/fault_event_fifo.sv
// Show-ahead FIFO for fault event records. The caller must not push when full
// unless it pops in the same cycle; clear empties it synchronously.
module fault_event_fifo #(
   parameter int WIDTH = 79,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_pop;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == (AW+1)'(DEPTH));
   assign count  = cnt_q;
   assign do_pop = pop && !empty;
   // Empty head reads as zero so stale storage never leaks onto the output.
   assign rdata  = empty ? '0 : mem[rd_q];

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_q] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clear) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push)   wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         case ({push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/fault_event_logger.sv
// Fault event logger: statistics, event FIFO and sticky consecutive-fault alarm.
// Optional FAULT_LOG_DELTA_EN adds max_delta, the largest observed scale gap.
//  state   | meaning
//  MONITOR | normal operation, consecutive faults below threshold
//  ALARM   | threshold reached; sticky until clear or rst
module fault_event_logger
   import fault_log_pkg::*;
#(
   parameter int NBITS      = 32,
   parameter int SCALE_W    = 7,
   parameter int DEPTH      = 8,
   parameter int CNT_W      = 16,
   parameter int MAX_CONSEC = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   fault_event_logger_if.slave    bus,
   output logic [CNT_W-1:0]       total_cnt,
   output logic [CNT_W-1:0]       fault_cnt,
   output logic [CNT_W-1:0]       trunc_cnt,
   output logic [$clog2(DEPTH):0] ev_count,
   output logic                   overflow,
`ifdef FAULT_LOG_DELTA_EN
   output logic [SCALE_W-1:0]     max_delta,
`endif
   output logic                   alarm
);
   localparam int          REC_W   = rec_w(NBITS, SCALE_W);
   localparam int          CW      = $clog2(MAX_CONSEC + 1);
   localparam logic [31:0] CNT_MAX = 32'((33'd1 << CNT_W) - 33'd1);

   state_t           state_q, state_d;
   logic [CW-1:0]    consec_q, consec_d;
   logic [CNT_W-1:0] total_q, fault_q, trunc_q;
   logic             ovf_q;
   logic             full, empty, push, pop, fault_in;
   logic [REC_W-1:0] rec;

   assign fault_in = bus.in_valid && bus.in_fault;
   assign pop      = !empty && bus.ev_ready;
   // A full FIFO still accepts a record when the head leaves in the same cycle.
   assign push     = fault_in && !clear && (!full || pop);
   assign rec      = {bus.in_mode, bus.in_true_sum, bus.in_used_sum,
                      bus.in_true_scale, bus.in_used_scale};

   fault_event_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (rec),
      .rdata (bus.ev_data),
      .full  (full),
      .empty (empty),
      .count (ev_count)
   );

   always_comb begin
      consec_d = consec_q;
      if (bus.in_valid)
         consec_d = bus.in_fault ? CW'(sat_inc(32'(consec_q), 32'(MAX_CONSEC))) : '0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MONITOR: if (bus.in_valid && consec_d == CW'(MAX_CONSEC)) state_d = ALARM;
         ALARM:   state_d = ALARM;
         default: state_d = MONITOR;
      endcase
      if (clear) state_d = MONITOR;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= MONITOR;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         total_q  <= '0;
         fault_q  <= '0;
         trunc_q  <= '0;
         consec_q <= '0;
         ovf_q    <= 1'b0;
      end else if (clear) begin
         total_q  <= '0;
         fault_q  <= '0;
         trunc_q  <= '0;
         consec_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (bus.in_valid) begin
            total_q <= CNT_W'(sat_inc(32'(total_q), CNT_MAX));
            if (bus.in_fault) fault_q <= CNT_W'(sat_inc(32'(fault_q), CNT_MAX));
            if (bus.in_mode)  trunc_q <= CNT_W'(sat_inc(32'(trunc_q), CNT_MAX));
         end
         consec_q <= consec_d;
         if (fault_in && full && !pop) ovf_q <= 1'b1;
      end
   end

`ifdef FAULT_LOG_DELTA_EN
   logic [SCALE_W-1:0] delta, max_q;

   assign delta = (bus.in_true_scale > bus.in_used_scale)
                ? bus.in_true_scale - bus.in_used_scale
                : bus.in_used_scale - bus.in_true_scale;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   max_q <= '0;
      else if (clear)                            max_q <= '0;
      else if (bus.in_valid && delta > max_q)    max_q <= delta;
   end

   assign max_delta = max_q;
`endif

   assign bus.ev_valid = !empty;
   assign total_cnt    = total_q;
   assign fault_cnt    = fault_q;
   assign trunc_cnt    = trunc_q;
   assign overflow     = ovf_q;
   assign alarm        = (state_q == ALARM);
endmodule

// File: doc/fault_event_logger.md
Name: fault_event_logger

Overview:
- Sequential stage directly downstream of the posit add fault checker.
- Samples the checker's per-operation result and keeps running statistics: total ops, faults, and truncated-mode ops.
- Buffers each faulting operation as an event record in a small FIFO, drained by a valid/ready consumer.
- Raises a sticky alarm after a run of consecutive faults.

Parameters:
- NBITS, 32, posit width of true/used sums.
- SCALE_W, 7, width of scale fields.
- DEPTH, 8, event FIFO entries; power of two, >= 2.
- CNT_W, 16, statistics counter width.
- MAX_CONSEC, 3, consecutive-fault count that triggers the alarm; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous clear of all state.
- in_valid  in  1  checker result valid this cycle.
- in_fault  in  1  checker fault flag.
- in_mode  in  1  1 = truncated adder used, 0 = full adder used.
- in_true_sum  in  NBITS  full-precision sum.
- in_used_sum  in  NBITS  checker sum actually used.
- in_true_scale  in  SCALE_W  scale of true sum.
- in_used_scale  in  SCALE_W  scale of used sum.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer accepts head.
- ev_data  out  2*NBITS+2*SCALE_W+1  record {mode, true_sum, used_sum, true_scale, used_scale}, MSB first.
- total_cnt  out  CNT_W  valid samples seen.
- fault_cnt  out  CNT_W  faulting samples seen.
- trunc_cnt  out  CNT_W  samples with in_mode=1.
- ev_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a fault event was dropped.
- alarm  out  1  high in ALARM state.

Behaviour:
- Reset (rst=1, async): all counters, ev_count, overflow, alarm, ev_valid = 0; FSM = MONITOR; FIFO pointers = 0; ev_data = 0.
- Sampling: inputs are consumed only on cycles with in_valid=1.
  - total_cnt +1 on every valid sample.
  - fault_cnt +1 when in_fault=1.
  - trunc_cnt +1 when in_mode=1.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Push: a valid sample with in_fault=1 pushes one record.
  - Record appears at the head one cycle later: ev_valid rises the cycle after the sample when the FIFO was empty.
  - FIFO is show-ahead: ev_data is registered and stable while ev_valid=1 and ev_ready=0.
- Pop: occurs when ev_valid and ev_ready are both 1.
- Full FIFO:
  - A push with no same-cycle pop drops the record, sets overflow, and leaves the FIFO unchanged.
  - Push and pop in the same cycle while full succeeds: occupancy unchanged, no overflow.
- Empty FIFO: ev_ready is ignored; ev_valid stays 0.
- Pointers wrap modulo DEPTH; ev_count ranges 0..DEPTH.
- Consecutive counter (internal):
  - +1 on a valid faulting sample, saturating at MAX_CONSEC.
  - Reset to 0 on a valid non-faulting sample.
  - Unchanged on idle cycles.
- FSM states: MONITOR and ALARM.
  - MONITOR -> ALARM when the update makes the consecutive counter equal MAX_CONSEC; alarm is high from the next cycle.
  - ALARM is sticky: it holds through non-fault samples; only clear or rst returns to MONITOR.
  - While in ALARM, counting and logging continue unchanged.
- clear=1: next cycle, state equals the reset state.
  - clear has priority over a same-cycle in_valid sample (sample discarded) and over pop.
- rst asserted mid-operation discards FIFO contents immediately.

Optional Feature:
- Macro: FAULT_LOG_DELTA_EN.
- Defined:
  - Adds output port max_delta (SCALE_W).
  - Holds the maximum |in_true_scale - in_used_scale| over all valid samples, computed unsigned as larger minus smaller.
  - Updates one cycle after the sample; reset and clear set it to 0.
- Undefined: port and logic are absent.

Decomposition:
- Shared package fault_log_pkg:
  - Record field widths and offsets derived from NBITS/SCALE_W.
  - FSM state enum {MONITOR, ALARM}.
  - Saturating-increment helper function.
- One natural sub-module: fault_event_fifo.
  - Parameterised width/depth, show-ahead.
  - Push/pop/full/empty/count outputs.
  - Drop-on-full is handled in the parent.

Test Plan:
- Reset then 4 valid samples with in_fault=0, in_mode=1 -> total_cnt=4, trunc_cnt=4, fault_cnt=0, ev_valid=0, alarm=0.
- One fault sample (true_sum=0x40000000, used_sum=0x48000000, scales 8/12, mode=0), ev_ready=0 -> ev_valid=1 next cycle, ev_data holds that record stably, ev_count=1.
- 9 fault samples with ev_ready=0, DEPTH=8 -> ev_count=8, overflow=1, fault_cnt=9.
  - Then a fault sample with ev_ready=1 in the same cycle -> ev_count stays 8.
- Fault sequence F,F,N,F,F,F (all valid, idle gaps between) -> alarm rises only after the 6th sample.
  - A following non-fault sample keeps alarm=1; clear -> alarm=0 and all counters 0.
- Force total_cnt to 0xFFFF with CNT_W=16, then one more valid sample -> total_cnt stays 0xFFFF.
- Assert rst asynchronously mid-burst with FIFO at 3 entries -> ev_valid=0 and ev_count=0 before the next clk edge.
  - With FAULT_LOG_DELTA_EN, samples with scale pairs (5,9), (20,18) -> max_delta=4.
